// File: rtl/obs_pkg.sv
// Shared types and constants for the observer dump sequencer.
// The item list walks PC, IR, the ALU operands/result and then the
// sixteen general registers, each selected through mode/select lines.
package obs_pkg;

  // Observer data word and register-select widths
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int INDEX_W    = 5;
  localparam int CNT_W      = 4;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  // Item list layout: 0 PC, 1 IR, 2..4 ALU, 5..20 registers 0..15
  localparam logic [INDEX_W-1:0] ITEM_LAST = 5'd20;
  localparam logic [INDEX_W-1:0] ALU_BASE  = 5'd2;
  localparam logic [INDEX_W-1:0] REG_BASE  = 5'd5;

  // Observer mode select codes
  localparam logic [2:0] MODE_PC  = 3'd0;
  localparam logic [2:0] MODE_IR  = 3'd1;
  localparam logic [2:0] MODE_ALU = 3'd2;
  localparam logic [2:0] MODE_REG = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SET  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_HOLD = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Index of the item following idx in the dump order
  function automatic logic [INDEX_W-1:0] next_index(input logic [INDEX_W-1:0] idx);
    return idx + 5'd1;
  endfunction

endpackage

// File: rtl/obs_item_map.sv
// Combinational lookup from dump item index to the observer mode and
// register/ALU select that expose that item on data_i.
module obs_item_map
  import obs_pkg::*;
(
  input  logic [INDEX_W-1:0]    i_index,
  output logic [2:0]            o_mode,
  output logic [REG_ADDR_W-1:0] o_sel
);

  logic [INDEX_W-1:0] w_alu_off;
  logic [INDEX_W-1:0] w_reg_off;

  assign w_alu_off = i_index - ALU_BASE;
  assign w_reg_off = i_index - REG_BASE;

  // Decode index into {mode, sel}; out-of-range indices park on PC
  always_comb begin
    o_mode = MODE_PC;
    o_sel  = '0;
    if (i_index < ALU_BASE) begin
      o_mode = (i_index == 5'd0) ? MODE_PC : MODE_IR;
    end else if (i_index < REG_BASE) begin
      o_mode = MODE_ALU;
      // ALU view order is operand A, operand B, then result
      case (w_alu_off)
        5'd0:    o_sel = 5'd1;
        5'd1:    o_sel = 5'd2;
        default: o_sel = 5'd0;
      endcase
    end else if (i_index <= ITEM_LAST) begin
      o_mode = MODE_REG;
      o_sel  = w_reg_off;
    end
  end

endmodule

// File: rtl/observer_seq.sv
// Observer dump sequencer: steps the observer through every item,
// waits for the selected path to settle, captures data_i and offers
// it downstream with a valid/ready handshake, optionally pausing for
// a manual step between items.
module observer_seq
  import obs_pkg::*;
#(
  parameter int SETTLE     = 2,
  parameter bit MANUAL_DEF = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  manual_i,
  input  logic                  step_i,
  input  logic [REG_W-1:0]      data_i,
  input  logic                  ready_i,
  output logic [2:0]            mode_o,
  output logic [REG_ADDR_W-1:0] reg_sel_o,
  output logic                  valid_o,
  output logic [REG_W-1:0]      data_o,
  output logic [4:0]            tag_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // The settle counter is CNT_W bits wide, which bounds SETTLE
  if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
    $error("observer_seq: SETTLE must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t                  r_state;
  logic [INDEX_W-1:0]      r_index;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_manual;
  logic [INDEX_W-1:0]      w_map_idx;
  logic [2:0]              w_mode;
  logic [REG_ADDR_W-1:0]   w_sel;
  logic                    w_last;

  // Index of the item about to enter SET: item 0 from IDLE, else the next one
  always_comb begin
    w_map_idx = next_index(r_index);
    if (r_state == ST_IDLE) begin
      w_map_idx = '0;
    end
  end

  assign w_last = (r_index == ITEM_LAST);

  obs_item_map u_item_map (
    .i_index (w_map_idx),
    .o_mode  (w_mode),
    .o_sel   (w_sel)
  );

  // Dump FSM with registered outputs; abort has priority over every handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_index   <= '0;
      r_cnt     <= '0;
      r_manual  <= MANUAL_DEF;
      mode_o    <= MODE_PC;
      reg_sel_o <= '0;
      valid_o   <= 1'b0;
      data_o    <= ZERO_WORD;
      tag_o     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      r_manual <= manual_i;
      done_o   <= 1'b0;
      if (abort_i && (r_state != ST_IDLE)) begin
        r_state   <= ST_IDLE;
        r_index   <= '0;
        r_cnt     <= '0;
        mode_o    <= MODE_PC;
        reg_sel_o <= '0;
        valid_o   <= 1'b0;
        busy_o    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              r_state   <= ST_SET;
              r_index   <= '0;
              mode_o    <= w_mode;
              reg_sel_o <= w_sel;
              busy_o    <= 1'b1;
            end
          end
          ST_SET: begin
            r_cnt   <= CNT_LOAD;
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (r_cnt == '0) begin
              data_o  <= data_i;
              tag_o   <= r_index;
              valid_o <= 1'b1;
              r_state <= ST_OUT;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_OUT: begin
            // Item stays frozen until downstream takes it
            if (ready_i) begin
              valid_o <= 1'b0;
              if (w_last) begin
                r_state <= ST_DONE;
                done_o  <= 1'b1;
              end else if (r_manual) begin
                r_state <= ST_HOLD;
              end else begin
                r_index   <= w_map_idx;
                mode_o    <= w_mode;
                reg_sel_o <= w_sel;
                r_state   <= ST_SET;
              end
            end
          end
          ST_HOLD: begin
            if (step_i) begin
              r_index   <= w_map_idx;
              mode_o    <= w_mode;
              reg_sel_o <= w_sel;
              r_state   <= ST_SET;
            end
          end
          ST_DONE: begin
            r_state   <= ST_IDLE;
            r_index   <= '0;
            mode_o    <= MODE_PC;
            reg_sel_o <= '0;
            busy_o    <= 1'b0;
          end
          default: begin
            r_state   <= ST_IDLE;
            r_index   <= '0;
            mode_o    <= MODE_PC;
            reg_sel_o <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
